// File: rtl/mem_load_result_queue.sv
// rtl/mem_load_result_queue.sv - in-order load result tracker, formatter and CDB arbiter
//
// Tracks loads issued by the memory reservation station and captures the
// in-order D-cache responses. Each response is formatted by load size, sign
// and byte offset, buffered, and presented to the CDB with a req/grant handshake.
// A flush discards all tracked loads and drops responses still in flight.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            branch-mispredict flush (highest priority)
//   ld_issue_*       load issued to the D-cache: valid, ROB tag, type, addr[1:0]
//   dc_resp_*        in-order D-cache response: valid, raw aligned word
//   cdb_grant        CDB accepts the current request
//   cdb_req/tag/data head result offered to the CDB
//   ld_stall         no free entry; station must not issue

module mem_load_result_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_BITS   = 4,
  parameter int DEPTH      = 4,
  parameter int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  ld_issue_valid,
  input  logic [TAG_BITS-1:0]   ld_issue_tag,
  input  logic [2:0]            ld_issue_type,
  input  logic [1:0]            ld_issue_off,
  input  logic                  dc_resp_valid,
  input  logic [DATA_WIDTH-1:0] dc_resp_data,
  input  logic                  cdb_grant,
  output logic                  cdb_req,
  output logic [TAG_BITS-1:0]   cdb_tag,
  output logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  ld_stall
);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  state_e                st_q   [DEPTH];
  logic [TAG_BITS-1:0]   tag_q  [DEPTH];
  logic [2:0]            type_q [DEPTH];
  logic [1:0]            off_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [DEPTH_BITS-1:0] alloc_ptr;
  logic [DEPTH_BITS-1:0] resp_ptr;
  logic [DEPTH_BITS-1:0] head_ptr;
  logic [DEPTH_BITS:0]   count_q;
  logic [DEPTH_BITS:0]   drop_q;

  logic                  do_issue;
  logic                  do_resp;
  logic                  do_drop;
  logic                  do_grant;
  logic [DEPTH_BITS:0]   pending_cnt;
  logic [DEPTH_BITS:0]   flush_drop;

  // Little-endian extraction; off[0] is ignored for halfwords, unknown
  // types fall back to a full-word pass-through.
  function automatic logic [DATA_WIDTH-1:0] fmt_load(
    input logic [2:0]            ty,
    input logic [1:0]            off,
    input logic [DATA_WIDTH-1:0] raw
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[8*off +: 8];
    h = raw[16*off[1] +: 16];
    case (ty)
      LT_LH:   fmt_load = {{(DATA_WIDTH-16){h[15]}}, h};
      LT_LHU:  fmt_load = {{(DATA_WIDTH-16){1'b0}}, h};
      LT_LB:   fmt_load = {{(DATA_WIDTH-8){b[7]}}, b};
      LT_LBU:  fmt_load = {{(DATA_WIDTH-8){1'b0}}, b};
      default: fmt_load = raw;
    endcase
  endfunction

  assign cdb_req  = (st_q[head_ptr] == ST_DONE);
  assign cdb_tag  = tag_q[head_ptr];
  assign cdb_data = data_q[head_ptr];
  // No bypass: a grant in the same cycle does not free the slot for an issue.
  assign ld_stall = (count_q == (DEPTH_BITS+1)'(DEPTH));

  assign do_issue = ld_issue_valid && !ld_stall;
  assign do_drop  = dc_resp_valid && (drop_q != '0);
  // A response with nothing pending is a protocol error and is ignored.
  assign do_resp  = dc_resp_valid && (drop_q == '0) && (st_q[resp_ptr] == ST_PENDING);
  assign do_grant = cdb_req && cdb_grant;

  // Loads still owed a response at a flush; a response arriving in the
  // flush cycle itself is one of them and is already accounted for.
  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i] == ST_PENDING) pending_cnt = pending_cnt + 1'b1;
    end
    if (dc_resp_valid && (pending_cnt != '0)) flush_drop = pending_cnt - 1'b1;
    else                                       flush_drop = pending_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= ST_FREE;
        tag_q[i]  <= '0;
        type_q[i] <= '0;
        off_q[i]  <= '0;
        data_q[i] <= '0;
      end
      alloc_ptr <= '0;
      resp_ptr  <= '0;
      head_ptr  <= '0;
      count_q   <= '0;
      drop_q    <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= ST_FREE;
      alloc_ptr <= '0;
      resp_ptr  <= '0;
      head_ptr  <= '0;
      count_q   <= '0;
      drop_q    <= flush_drop;
    end else begin
      // Issue targets a FREE slot, response a PENDING one and grant a DONE
      // one, so the three writes never collide on the same entry.
      if (do_issue) begin
        st_q[alloc_ptr]   <= ST_PENDING;
        tag_q[alloc_ptr]  <= ld_issue_tag;
        type_q[alloc_ptr] <= ld_issue_type;
        off_q[alloc_ptr]  <= ld_issue_off;
        alloc_ptr         <= alloc_ptr + DEPTH_BITS'(1);
      end
      if (do_resp) begin
        st_q[resp_ptr]   <= ST_DONE;
        data_q[resp_ptr] <= fmt_load(type_q[resp_ptr], off_q[resp_ptr], dc_resp_data);
        resp_ptr         <= resp_ptr + DEPTH_BITS'(1);
      end
      if (do_grant) begin
        st_q[head_ptr] <= ST_FREE;
        head_ptr       <= head_ptr + DEPTH_BITS'(1);
      end
      if (do_drop) drop_q <= drop_q - 1'b1;
      count_q <= count_q + {{DEPTH_BITS{1'b0}}, do_issue} - {{DEPTH_BITS{1'b0}}, do_grant};
    end
  end

endmodule

// File: tb/tb_mem_load_result_queue.sv
// tb/tb_mem_load_result_queue.sv - self-checking bench for mem_load_result_queue

module tb_mem_load_result_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        ld_issue_valid;
  logic [3:0]  ld_issue_tag;
  logic [2:0]  ld_issue_type;
  logic [1:0]  ld_issue_off;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_data;
  logic        cdb_grant;
  logic        cdb_req;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        ld_stall;

  int n_cmp = 0;
  int n_bad = 0;

  mem_load_result_queue #(.DATA_WIDTH(32), .TAG_BITS(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ld_issue_valid(ld_issue_valid), .ld_issue_tag(ld_issue_tag),
    .ld_issue_type(ld_issue_type), .ld_issue_off(ld_issue_off),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .cdb_grant(cdb_grant), .cdb_req(cdb_req), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .ld_stall(ld_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: outstanding loads as two ordered lists.
  typedef struct { logic [3:0] tag; int ty; int off; } pend_t;
  typedef struct { logic [3:0] tag; logic [31:0] data; } done_t;
  pend_t m_pend[$];
  done_t m_done[$];
  int    m_drop;

  function automatic logic [31:0] ref_fmt(int ty, int off, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (ty)
      1: return h[15] ? (h | 32'hFFFF0000) : h;
      2: return h;
      3: return b[7] ? (b | 32'hFFFFFF00) : b;
      4: return b;
      default: return w;
    endcase
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clr;
    flush = 0; ld_issue_valid = 0; ld_issue_tag = 0; ld_issue_type = 0;
    ld_issue_off = 0; dc_resp_valid = 0; dc_resp_data = 0; cdb_grant = 0;
  endtask

  task automatic issue(input logic [3:0] tag, input logic [2:0] ty, input logic [1:0] off);
    ld_issue_valid = 1; ld_issue_tag = tag; ld_issue_type = ty; ld_issue_off = off;
    tick; clr;
  endtask

  task automatic respond(input logic [31:0] d);
    dc_resp_valid = 1; dc_resp_data = d;
    tick; clr;
  endtask

  task automatic grant;
    cdb_grant = 1;
    tick; clr;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (cdb_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", cdb_req); end
    n_cmp++; if (cdb_tag !== 4'd0) begin n_bad++; $display("FAIL reset_tag got %0d want 0", cdb_tag); end
    n_cmp++; if (cdb_data !== 32'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", cdb_data); end
    n_cmp++; if (ld_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", ld_stall); end
    tick; tick;
    rst_n = 1;
    tick;
  endtask

  task automatic test_lw;
    issue(4'd3, 3'd0, 2'd0);
    n_cmp++; if (cdb_req !== 1'b0) begin n_bad++; $display("FAIL lw_req_pending got %b want 0", cdb_req); end
    respond(32'hDEADBEEF);
    n_cmp++; if (cdb_req !== 1'b1) begin n_bad++; $display("FAIL lw_req got %b want 1", cdb_req); end
    n_cmp++; if (cdb_tag !== 4'd3) begin n_bad++; $display("FAIL lw_tag got %0d want 3", cdb_tag); end
    n_cmp++; if (cdb_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data got %h want deadbeef", cdb_data); end
    grant;
    n_cmp++; if (cdb_req !== 1'b0) begin n_bad++; $display("FAIL lw_req_after_grant got %b want 0", cdb_req); end
  endtask

  task automatic test_format;
    logic [2:0]  tys  [5] = '{3'd3, 3'd4, 3'd3, 3'd1, 3'd2};
    logic [1:0]  offs [5] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd0};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00000001, 32'hFFFF80FF, 32'h00007F01};
    for (int i = 0; i < 5; i++) begin
      issue(4'(i + 8), tys[i], offs[i]);
      respond(32'h80FF7F01);
      n_cmp++; if (cdb_req !== 1'b1 || cdb_data !== exps[i])
        begin n_bad++; $display("FAIL fmt_%0d got req=%b data=%h want req=1 data=%h", i, cdb_req, cdb_data, exps[i]); end
      grant;
    end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 4; i++) issue(4'(i), 3'd0, 2'd0);
    n_cmp++; if (ld_stall !== 1'b1) begin n_bad++; $display("FAIL fill_stall got %b want 1", ld_stall); end
    issue(4'd5, 3'd0, 2'd0);
    n_cmp++; if (ld_stall !== 1'b1) begin n_bad++; $display("FAIL fill_stall_after_5th got %b want 1", ld_stall); end
    for (int i = 1; i <= 4; i++) respond(32'h1000 + 32'(i));
    n_cmp++; if (cdb_req !== 1'b1 || ld_stall !== 1'b1)
      begin n_bad++; $display("FAIL fill_all_done got req=%b stall=%b want 1 1", cdb_req, ld_stall); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (cdb_tag !== 4'(i) || cdb_data !== 32'h1000 + 32'(i))
        begin n_bad++; $display("FAIL fill_order_%0d got tag=%0d data=%h want tag=%0d data=%h", i, cdb_tag, cdb_data, i, 32'h1000 + 32'(i)); end
      grant;
      if (i == 1) begin
        n_cmp++; if (ld_stall !== 1'b0) begin n_bad++; $display("FAIL fill_stall_release got %b want 0", ld_stall); end
      end
    end
    n_cmp++; if (cdb_req !== 1'b0) begin n_bad++; $display("FAIL fill_empty_req got %b want 0", cdb_req); end
  endtask

  task automatic test_hold;
    logic [3:0]  et [4] = '{4'd6, 4'd8, 4'd9, 4'd10};
    logic [31:0] ed [4] = '{32'hB0B0_0001, 32'hC0C0_0002, 32'hD0D0_0003, 32'hE0E0_0004};
    issue(4'd5, 3'd0, 2'd0);
    issue(4'd6, 3'd0, 2'd0);
    issue(4'd8, 3'd0, 2'd0);
    respond(32'hA0A0_0000);
    respond(ed[0]);
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (cdb_req !== 1'b1 || cdb_tag !== 4'd5 || cdb_data !== 32'hA0A0_0000)
        begin n_bad++; $display("FAIL hold_cycle_%0d got req=%b tag=%0d data=%h want 1 5 a0a00000", i, cdb_req, cdb_tag, cdb_data); end
      tick;
    end
    // issue + response + grant in one cycle leaves occupancy at 3
    ld_issue_valid = 1; ld_issue_tag = 4'd9; dc_resp_valid = 1; dc_resp_data = ed[1]; cdb_grant = 1;
    tick; clr;
    n_cmp++; if (cdb_tag !== 4'd6 || ld_stall !== 1'b0)
      begin n_bad++; $display("FAIL simul_head got tag=%0d stall=%b want 6 0", cdb_tag, ld_stall); end
    issue(4'd10, 3'd0, 2'd0);
    n_cmp++; if (ld_stall !== 1'b1) begin n_bad++; $display("FAIL simul_count_stall got %b want 1", ld_stall); end
    respond(ed[2]);
    respond(ed[3]);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cdb_req !== 1'b1 || cdb_tag !== et[i] || cdb_data !== ed[i])
        begin n_bad++; $display("FAIL simul_drain_%0d got req=%b tag=%0d data=%h want 1 %0d %h", i, cdb_req, cdb_tag, cdb_data, et[i], ed[i]); end
      grant;
    end
  endtask

  task automatic test_flush;
    for (int i = 1; i <= 3; i++) issue(4'(i), 3'd0, 2'd0);
    flush = 1; tick; clr;
    issue(4'd7, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      respond(32'h1111_1111 * 32'(i + 1));
      n_cmp++; if (cdb_req !== 1'b0) begin n_bad++; $display("FAIL flush_drop_%0d got req=%b want 0", i, cdb_req); end
    end
    respond(32'hCAFEF00D);
    n_cmp++; if (cdb_req !== 1'b1 || cdb_tag !== 4'd7 || cdb_data !== 32'hCAFEF00D)
      begin n_bad++; $display("FAIL flush_new_load got req=%b tag=%0d data=%h want 1 7 cafef00d", cdb_req, cdb_tag, cdb_data); end
    grant;
  endtask

  task automatic test_async_reset;
    for (int i = 1; i <= 4; i++) issue(4'(i), 3'd0, 2'd0);
    respond(32'h5555_0001);
    respond(32'h5555_0002);
    n_cmp++; if (cdb_req !== 1'b1 || ld_stall !== 1'b1)
      begin n_bad++; $display("FAIL areset_pre got req=%b stall=%b want 1 1", cdb_req, ld_stall); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (cdb_req !== 1'b0 || ld_stall !== 1'b0)
      begin n_bad++; $display("FAIL areset_immediate got req=%b stall=%b want 0 0", cdb_req, ld_stall); end
    tick;
    rst_n = 1;
    tick;
    respond(32'h5555_0003);
    respond(32'h5555_0004);
    n_cmp++; if (cdb_req !== 1'b0 || ld_stall !== 1'b0)
      begin n_bad++; $display("FAIL areset_after got req=%b stall=%b want 0 0", cdb_req, ld_stall); end
  endtask

  task automatic test_random;
    logic       f, iv, rv, g, stall_m, req_m;
    logic [3:0] tg;
    int         ty, off;
    logic [31:0] d;
    pend_t      p;
    m_pend.delete(); m_done.delete(); m_drop = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_m   = (m_done.size() > 0);
      stall_m = ((m_pend.size() + m_done.size()) == 4);
      n_cmp++; if (cdb_req !== req_m || ld_stall !== stall_m)
        begin n_bad++; $display("FAIL rand_ctl_%0d got req=%b stall=%b want %b %b", cyc, cdb_req, ld_stall, req_m, stall_m); end
      if (req_m) begin
        n_cmp++; if (cdb_tag !== m_done[0].tag || cdb_data !== m_done[0].data)
          begin n_bad++; $display("FAIL rand_data_%0d got tag=%0d data=%h want %0d %h", cyc, cdb_tag, cdb_data, m_done[0].tag, m_done[0].data); end
      end
      f   = (m_drop == 0) && ($urandom_range(0, 39) == 0);
      iv  = $urandom_range(0, 1) == 1;
      tg  = 4'($urandom);
      ty  = $urandom_range(0, 7);
      off = $urandom_range(0, 3);
      rv  = $urandom_range(0, 2) != 0;
      d   = $urandom;
      g   = $urandom_range(0, 1) == 1;
      flush = f; ld_issue_valid = iv; ld_issue_tag = tg; ld_issue_type = 3'(ty);
      ld_issue_off = 2'(off); dc_resp_valid = rv; dc_resp_data = d; cdb_grant = g;
      if (f) begin
        m_drop = m_pend.size() - (rv ? 1 : 0);
        if (m_drop < 0) m_drop = 0;
        m_pend.delete(); m_done.delete();
      end else begin
        if (req_m && g) void'(m_done.pop_front());
        if (rv) begin
          if (m_drop > 0) m_drop--;
          else if (m_pend.size() > 0) begin
            p = m_pend.pop_front();
            m_done.push_back('{tag: p.tag, data: ref_fmt(p.ty, p.off, d)});
          end
        end
        if (iv && !stall_m) m_pend.push_back('{tag: tg, ty: ty, off: off});
      end
      tick;
    end
    clr;
  endtask

  initial begin
    clk = 0;
    rst_n = 0;
    clr;
    test_reset;
    test_lw;
    test_format;
    test_fill;
    test_hold;
    test_flush;
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
